// File: rtl/riscv_regfile.sv
// riscv_regfile
// Architectural register file with a per-register lock scoreboard. Each
// register carries a small pending-writer counter so that several in-flight
// producers can hold a lock on the same destination. Index 0 is hard-wired
// to zero and can never be locked.
module riscv_regfile #(
  parameter int REGISTER_PORTS = 2,
  parameter int LOCK_CNT_W     = 2
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [REGISTER_PORTS-1:0]            register_lock_en,
  input  logic [REGISTER_PORTS-1:0][4:0]       register_lock,
  input  logic [REGISTER_PORTS-1:0]            register_write_en,
  input  logic [REGISTER_PORTS-1:0][4:0]       register_write,
  input  logic [REGISTER_PORTS-1:0][31:0]      register_write_data,
  output logic [31:0][31:0]                    register,
  output logic [31:0]                          register_locked,
  output logic                                 scoreboard_err,
  output logic [63:0]                          write_count
);

  // Counter arithmetic is done two bits wider than the counter so that
  // both overflow (cnt + P) and underflow (0 - P) are representable.
  localparam int CW = LOCK_CNT_W + 2;
  localparam logic [LOCK_CNT_W-1:0] CNT_MAX   = {LOCK_CNT_W{1'b1}};
  localparam logic signed [CW-1:0]  CNT_MAX_S = $signed({2'b00, CNT_MAX});
  localparam logic signed [CW-1:0]  ZERO_S    = $signed({CW{1'b0}});
  localparam logic [CW-1:0]         ONE_CW    = {{(CW-1){1'b0}}, 1'b1};

  logic [LOCK_CNT_W-1:0] cnt_r      [32];
  logic [LOCK_CNT_W-1:0] cnt_next_s [32];
  logic [CW-1:0]         inc_s      [32];
  logic [CW-1:0]         dec_s      [32];
  logic signed [CW-1:0]  sum_s      [32];
  logic [31:0]           err_vec_s;
  logic [31:0][31:0]     reg_next_s;
  logic [63:0]           wc_inc_s;

  // Number of ports whose enable is set and whose index equals r.
  function automatic logic [CW-1:0] count_hits(
    input logic [REGISTER_PORTS-1:0]      en,
    input logic [REGISTER_PORTS-1:0][4:0] idx,
    input logic [4:0]                     r
  );
    logic [CW-1:0] n;
    n = {CW{1'b0}};
    for (int p = 0; p < REGISTER_PORTS; p++) begin
      if (en[p] && (idx[p] == r)) begin
        n = n + ONE_CW;
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // Number of active write ports that target a real (non-x0) register.
  function automatic logic [63:0] count_writes(
    input logic [REGISTER_PORTS-1:0]      en,
    input logic [REGISTER_PORTS-1:0][4:0] idx
  );
    logic [63:0] n;
    n = 64'd0;
    for (int p = 0; p < REGISTER_PORTS; p++) begin
      if (en[p] && (idx[p] != 5'd0)) begin
        n = n + 64'd1;
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // Next pending count per register, with saturation/clamp and error flags.
  always_comb begin
    for (int r = 0; r < 32; r++) begin
      inc_s[r] = count_hits(register_lock_en, register_lock, 5'(r));
      dec_s[r] = count_hits(register_write_en, register_write, 5'(r));
      sum_s[r] = $signed({2'b00, cnt_r[r]}) + $signed(inc_s[r]) - $signed(dec_s[r]);
      if (r == 0) begin
        cnt_next_s[r] = {LOCK_CNT_W{1'b0}};
        err_vec_s[r]  = 1'b0;
      end else if (sum_s[r] > CNT_MAX_S) begin
        cnt_next_s[r] = CNT_MAX;
        err_vec_s[r]  = 1'b1;
      end else if (sum_s[r] < ZERO_S) begin
        cnt_next_s[r] = {LOCK_CNT_W{1'b0}};
        err_vec_s[r]  = 1'b1;
      end else begin
        cnt_next_s[r] = sum_s[r][LOCK_CNT_W-1:0];
        // A write landing on a register nobody had locked is still flagged
        // even when a same-cycle lock keeps the arithmetic in range.
        err_vec_s[r]  = (cnt_r[r] == {LOCK_CNT_W{1'b0}}) && (dec_s[r] != {CW{1'b0}});
      end
    end
  end

  // Next register contents: ports applied in ascending order so the highest port wins.
  always_comb begin
    reg_next_s = register;
    for (int p = 0; p < REGISTER_PORTS; p++) begin
      reg_next_s[register_write[p]] =
        (register_write_en[p] && (register_write[p] != 5'd0)) ?
        register_write_data[p] : reg_next_s[register_write[p]];
    end
    reg_next_s[0] = 32'h0000_0000;
    wc_inc_s      = count_writes(register_write_en, register_write);
  end

  // Locked vector straight from the counter flops; x0 never locks.
  always_comb begin
    register_locked[0] = 1'b0;
    for (int r = 1; r < 32; r++) begin
      register_locked[r] = |cnt_r[r];
    end
  end

  // State update: registers, counters, sticky error and writeback counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      register       <= '0;
      scoreboard_err <= 1'b0;
      write_count    <= 64'd0;
      for (int r = 0; r < 32; r++) begin
        cnt_r[r] <= {LOCK_CNT_W{1'b0}};
      end
    end else begin
      register       <= reg_next_s;
      scoreboard_err <= scoreboard_err | (|err_vec_s);
      write_count    <= write_count + wc_inc_s;
      for (int r = 0; r < 32; r++) begin
        cnt_r[r] <= cnt_next_s[r];
      end
    end
  end

endmodule

// File: tb/tb_riscv_regfile.sv
// Testbench for riscv_regfile: directed scenarios followed by randomized
// traffic, all compared against a simple array/integer reference model.
module tb_riscv_regfile;

  localparam int P    = 2;
  localparam int LW   = 2;
  localparam int CMAX = (1 << LW) - 1;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [P-1:0]         lock_en;
  logic [P-1:0][4:0]    lock_idx;
  logic [P-1:0]         write_en;
  logic [P-1:0][4:0]    write_idx;
  logic [P-1:0][31:0]   write_data;
  logic [31:0][31:0]    reg_out;
  logic [31:0]          locked;
  logic                 err;
  logic [63:0]          wcount;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0]     m_reg [32];
  int              m_cnt [32];
  bit              m_err;
  longint unsigned m_wc;

  logic [63:0] wc_before;

  riscv_regfile #(.REGISTER_PORTS(P), .LOCK_CNT_W(LW)) dut (
    .clock               (clock),
    .reset               (reset),
    .register_lock_en    (lock_en),
    .register_lock       (lock_idx),
    .register_write_en   (write_en),
    .register_write      (write_idx),
    .register_write_data (write_data),
    .register            (reg_out),
    .register_locked     (locked),
    .scoreboard_err      (err),
    .write_count         (wcount)
  );

  // 100 MHz clock
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_reg[r] = 32'h0;
      m_cnt[r] = 0;
    end
    m_err = 1'b0;
    m_wc  = 64'd0;
  endtask

  // Apply one clock edge worth of the rules to the model.
  task automatic model_edge();
    for (int r = 1; r < 32; r++) begin
      int inc;
      int dec;
      int nxt;
      inc = 0;
      dec = 0;
      for (int p = 0; p < P; p++) begin
        if (lock_en[p] && lock_idx[p] == r) inc++;
        if (write_en[p] && write_idx[p] == r) dec++;
      end
      if (m_cnt[r] == 0 && dec > 0) m_err = 1'b1;
      nxt = m_cnt[r] + inc - dec;
      if (nxt > CMAX) begin
        m_cnt[r] = CMAX;
        m_err = 1'b1;
      end else if (nxt < 0) begin
        m_cnt[r] = 0;
        m_err = 1'b1;
      end else begin
        m_cnt[r] = nxt;
      end
    end
    for (int p = 0; p < P; p++) begin
      if (write_en[p] && write_idx[p] != 5'd0) begin
        m_reg[write_idx[p]] = write_data[p];
        m_wc = m_wc + 1;
      end
    end
  endtask

  task automatic compare_all(input string where);
    logic [31:0] exp_locked;
    for (int r = 0; r < 32; r++) begin
      check_val($sformatf("%s reg[%0d]", where, r), 64'(reg_out[r]), 64'(m_reg[r]));
      exp_locked[r] = (m_cnt[r] != 0);
    end
    check_val({where, " locked"}, 64'(locked), 64'(exp_locked));
    check_val({where, " err"}, 64'(err), 64'(m_err));
    check_val({where, " write_count"}, wcount, m_wc);
  endtask

  task automatic check_zero(input string where);
    check_val({where, " any reg"}, 64'(|reg_out), 64'd0);
    check_val({where, " locked"}, 64'(locked), 64'd0);
    check_val({where, " err"}, 64'(err), 64'd0);
    check_val({where, " write_count"}, wcount, 64'd0);
  endtask

  task automatic clear_in();
    lock_en    = '0;
    lock_idx   = '0;
    write_en   = '0;
    write_idx  = '0;
    write_data = '0;
  endtask

  // Advance one edge, update the model, then compare just after the edge.
  task automatic cycle(input string where);
    @(posedge clock);
    model_edge();
    #1;
    compare_all(where);
  endtask

  // Reset asserted between edges with inputs still active; outputs must clear at once.
  task automatic async_reset(input string where);
    #2;
    reset = 1'b0;
    #1;
    check_zero(where);
    model_reset();
    clear_in();
    @(negedge clock);
    reset = 1'b1;
    cycle({where, " post"});
  endtask

  initial begin
    clear_in();
    reset = 1'b0;
    model_reset();
    #12;
    check_zero("in reset");
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_zero("after release");
    cycle("idle");

    // Single lock then write on x5
    lock_en = 2'b01; lock_idx[0] = 5'd5;
    cycle("lock5"); clear_in();
    check_val("lock5 locked", 64'(locked[5]), 64'd1);
    cycle("hold5");
    write_en = 2'b01; write_idx[0] = 5'd5; write_data[0] = 32'hDEAD_BEEF;
    cycle("write5"); clear_in();
    check_val("write5 data", 64'(reg_out[5]), 64'hDEAD_BEEF);
    check_val("write5 unlocked", 64'(locked[5]), 64'd0);

    // Two pending writers on x7
    lock_en = 2'b01; lock_idx[0] = 5'd7;
    cycle("lock7a"); clear_in();
    lock_en = 2'b10; lock_idx[1] = 5'd7;
    cycle("lock7b"); clear_in();
    write_en = 2'b01; write_idx[0] = 5'd7; write_data[0] = 32'h11;
    cycle("write7a"); clear_in();
    check_val("write7a still locked", 64'(locked[7]), 64'd1);
    write_en = 2'b10; write_idx[1] = 5'd7; write_data[1] = 32'h55;
    cycle("write7b"); clear_in();
    check_val("write7b unlocked", 64'(locked[7]), 64'd0);
    check_val("write7b data", 64'(reg_out[7]), 64'h55);

    // Lock and write x3 in the same cycle with one pending lock
    lock_en = 2'b01; lock_idx[0] = 5'd3;
    cycle("lock3"); clear_in();
    lock_en = 2'b01; lock_idx[0] = 5'd3;
    write_en = 2'b01; write_idx[0] = 5'd3; write_data[0] = 32'hA5A5_A5A5;
    cycle("lockwrite3"); clear_in();
    check_val("lockwrite3 locked", 64'(locked[3]), 64'd1);
    check_val("lockwrite3 data", 64'(reg_out[3]), 64'hA5A5_A5A5);
    write_en = 2'b01; write_idx[0] = 5'd3; write_data[0] = 32'h3;
    cycle("write3"); clear_in();
    check_val("write3 unlocked", 64'(locked[3]), 64'd0);

    // Both ports write x9: highest port wins
    lock_en = 2'b11; lock_idx[0] = 5'd9; lock_idx[1] = 5'd9;
    cycle("lock9"); clear_in();
    wc_before = wcount;
    write_en = 2'b11; write_idx[0] = 5'd9; write_idx[1] = 5'd9;
    write_data[0] = 32'h1; write_data[1] = 32'h2;
    cycle("dual9"); clear_in();
    check_val("dual9 data", 64'(reg_out[9]), 64'h2);
    check_val("dual9 count", wcount, wc_before + 64'd2);
    check_val("dual9 err", 64'(err), 64'd0);

    // x0 is ignored
    wc_before = wcount;
    lock_en = 2'b11; write_en = 2'b11;
    write_data[0] = 32'hFFFF; write_data[1] = 32'hFFFF;
    cycle("x0"); clear_in();
    check_val("x0 data", 64'(reg_out[0]), 64'd0);
    check_val("x0 locked", 64'(locked[0]), 64'd0);
    check_val("x0 count", wcount, wc_before);
    check_val("x0 err", 64'(err), 64'd0);

    // Write to unlocked x4 sets sticky error
    write_en = 2'b01; write_idx[0] = 5'd4; write_data[0] = 32'h44;
    cycle("unlocked4"); clear_in();
    check_val("unlocked4 err", 64'(err), 64'd1);
    check_val("unlocked4 data", 64'(reg_out[4]), 64'h44);
    cycle("err held");
    check_val("err held", 64'(err), 64'd1);

    // Four locks on x6 saturate at 3: three writes release it
    lock_en = 2'b11; lock_idx[0] = 5'd6; lock_idx[1] = 5'd6;
    cycle("lock6a");
    cycle("lock6b"); clear_in();
    check_val("sat6 locked", 64'(locked[6]), 64'd1);
    for (int k = 0; k < 3; k++) begin
      write_en = 2'b01; write_idx[0] = 5'd6; write_data[0] = 32'(k + 100);
      cycle("drain6"); clear_in();
      check_val($sformatf("drain6 step %0d locked", k), 64'(locked[6]), (k < 2) ? 64'd1 : 64'd0);
    end

    // Async reset with x8 locked and a write in progress
    lock_en = 2'b01; lock_idx[0] = 5'd8;
    cycle("lock8"); clear_in();
    write_en = 2'b01; write_idx[0] = 5'd8; write_data[0] = 32'h88;
    async_reset("midreset");

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if (i % 75 == 74) begin
        lock_en = 2'($urandom_range(0, 3));
        lock_idx[0] = 5'($urandom_range(0, 9));
        lock_idx[1] = 5'($urandom_range(0, 9));
        async_reset("rand reset");
      end else begin
        for (int p = 0; p < P; p++) begin
          lock_en[p]    = ($urandom_range(0, 2) == 0);
          lock_idx[p]   = 5'($urandom_range(0, 9));
          write_en[p]   = ($urandom_range(0, 2) == 0);
          write_idx[p]  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
          write_data[p] = $urandom;
        end
        cycle("rand");
      end
    end
    clear_in();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
